// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM encoding, oversampling ratio and
// baud divider helper, reusable by a future transmitter.
package uart_pkg;

  localparam int unsigned OVERSAMPLE = 16;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_START = 3'd1;
  localparam logic [2:0] ST_DATA  = 3'd2;
  localparam logic [2:0] ST_STOP  = 3'd3;
  localparam logic [2:0] ST_BREAK = 3'd4;

  function automatic int unsigned uart_div(
    input int unsigned clk_hz,
    input int unsigned baud
  );
    int unsigned d;
    d = (clk_hz + (OVERSAMPLE / 2) * baud)
      / (OVERSAMPLE * baud);
    return (d < 1) ? 1 : d;
  endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// First-word fall-through byte FIFO for the UART receiver,
// flagging pushes that arrive while full with no pop.
module uart_rx_fifo #(
  parameter int unsigned DEPTH = 4
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       push_i,
  input  logic [7:0] data_i,
  input  logic       ready_i,
  output logic [7:0] data_o,
  output logic       valid_o,
  output logic       overrun_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_q;
  logic [AW-1:0] rd_q;
  logic [AW:0]   cnt_q;
  logic          ovr_q;

  logic empty;
  logic full;
  logic pop;
  logic wr_en;

  assign empty = (cnt_q == '0);
  assign full  = (cnt_q == FULL_CNT);
  assign pop   = ready_i & ~empty;
  // A pop frees the slot in the same cycle, so full+pop still accepts.
  assign wr_en = push_i & (~full | pop);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
      ovr_q <= 1'b0;
    end else begin
      ovr_q <= push_i & full & ~pop;
      if (wr_en) begin
        mem_q[wr_q] <= data_i;
        wr_q        <= wr_q + 1'b1;
      end
      if (pop) begin
        rd_q <= rd_q + 1'b1;
      end
      unique case ({wr_en, pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  assign data_o    = mem_q[rd_q];
  assign valid_o   = ~empty;
  assign overrun_o = ovr_q;

endmodule

// File: rtl/uart_rx_core.sv
// Oversampling UART receiver: synchroniser, 16x tick generator,
// majority-vote bit FSM and a small receive FIFO.
module uart_rx_core
  import uart_pkg::*;
#(
  parameter int unsigned CLK_HZ     = 50_000_000,
  parameter int unsigned BAUD       = 115200,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       rxd,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       frame_err,
  output logic       overrun,
  output logic       busy
);

  localparam int unsigned DIV = uart_div(CLK_HZ, BAUD);
  localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);

  logic          sync_q;
  logic          rxs_q;
  logic [2:0]    state_q, state_d;
  logic [DW-1:0] div_q, div_d;
  logic [3:0]    tck_q, tck_d;
  logic [2:0]    smp_q, smp_d;
  logic [2:0]    idx_q, idx_d;
  logic [7:0]    shf_q, shf_d;
  logic          fe_q, fe_d;

  logic tick;
  logic run;
  logic maj;
  logic last;
  logic mid;
  logic push;

  assign tick = (div_q == DIV_LAST);
  assign run  = (state_q == ST_START) ||
                (state_q == ST_DATA)  ||
                (state_q == ST_STOP);
  assign last = run & tick & (tck_q == 4'd15);
  assign mid  = run & tick & (tck_q == 4'd9);

  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    tck_d   = tck_q;
    smp_d   = smp_q;
    idx_d   = idx_q;
    shf_d   = shf_q;
    fe_d    = 1'b0;
    push    = 1'b0;

    // Bit timing only runs inside a frame so every frame starts aligned.
    if (!run) begin
      div_d = '0;
      tck_d = '0;
      smp_d = '0;
    end else begin
      div_d = tick ? '0 : div_q + 1'b1;
      if (tick) begin
        tck_d = tck_q + 4'd1;
        if (tck_q >= 4'd7 && tck_q <= 4'd9) begin
          smp_d = {smp_q[1:0], rxs_q};
        end
      end
    end

    maj = (smp_d[0] & smp_d[1]) |
          (smp_d[0] & smp_d[2]) |
          (smp_d[1] & smp_d[2]);

    unique case (state_q)
      ST_IDLE: begin
        if (!rxs_q) state_d = ST_START;
      end
      ST_START: begin
        if (last) begin
          state_d = maj ? ST_IDLE : ST_DATA;
          idx_d   = 3'd0;
        end
      end
      ST_DATA: begin
        if (last) begin
          shf_d[idx_q] = maj;
          idx_d        = idx_q + 3'd1;
          if (idx_q == 3'd7) state_d = ST_STOP;
        end
      end
      // Deciding mid-stop leaves time to catch the next start edge.
      ST_STOP: begin
        if (mid) begin
          push    = maj;
          fe_d    = ~maj;
          state_d = maj ? ST_IDLE : ST_BREAK;
        end
      end
      ST_BREAK: begin
        if (rxs_q) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q  <= 1'b1;
      rxs_q   <= 1'b1;
      state_q <= ST_IDLE;
      div_q   <= '0;
      tck_q   <= '0;
      smp_q   <= '0;
      idx_q   <= '0;
      shf_q   <= '0;
      fe_q    <= 1'b0;
    end else begin
      sync_q  <= rxd;
      rxs_q   <= sync_q;
      state_q <= state_d;
      div_q   <= div_d;
      tck_q   <= tck_d;
      smp_q   <= smp_d;
      idx_q   <= idx_d;
      shf_q   <= shf_d;
      fe_q    <= fe_d;
    end
  end

  uart_rx_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .reset_n  (reset_n),
    .push_i   (push),
    .data_i   (shf_d),
    .ready_i  (rx_ready),
    .data_o   (rx_data),
    .valid_o  (rx_valid),
    .overrun_o(overrun)
  );

  assign frame_err = fe_q;
  assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_rx_core.sv
// Directed bench for uart_rx_core: received bytes are checked
// against a scoreboard queue filled as frames are driven.
module tb_uart_rx_core;

  localparam int unsigned CLK_HZ = 3_200_000;
  localparam int unsigned BAUD   = 100_000;
  localparam int BIT = 32;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       rxd = 1'b1;
  logic       rx_ready = 1'b1;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_err;
  logic       overrun;
  logic       busy;

  int checks = 0;
  int failures = 0;
  int fe_cnt = 0;
  int ov_cnt = 0;
  int rx_cnt = 0;
  logic [7:0] exp_q [$];

  uart_rx_core #(
    .CLK_HZ    (CLK_HZ),
    .BAUD      (BAUD),
    .FIFO_DEPTH(4)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .rxd      (rxd),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .rx_ready (rx_ready),
    .frame_err(frame_err),
    .overrun  (overrun),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  task automatic check(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (frame_err === 1'b1) fe_cnt++;
    if (overrun === 1'b1) ov_cnt++;
    if (reset_n && rx_valid && rx_ready) begin
      rx_cnt++;
      if (exp_q.size() == 0)
        check("unexpected_byte", 32'(rx_data), 32'hFFFF_FFFF);
      else
        check("rx_byte", 32'(rx_data), 32'(exp_q.pop_front()));
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic line(input logic v, input int n);
    rxd = v;
    step(n);
  endtask

  task automatic send(input logic [7:0] b, input logic stop);
    line(1'b0, BIT);
    for (int i = 0; i < 8; i++) line(b[i], BIT);
    line(stop, BIT);
  endtask

  initial begin
    step(3);
    check("rst_valid", 32'(rx_valid), 32'd0);
    check("rst_data", 32'(rx_data), 32'h00);
    check("rst_fe", 32'(frame_err), 32'd0);
    check("rst_ov", 32'(overrun), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    reset_n = 1'b1;
    step(5);

    exp_q.push_back(8'hA5);
    send(8'hA5, 1'b1);
    step(20);
    check("a5_left", 32'(exp_q.size()), 32'd0);
    check("a5_fe", 32'(fe_cnt), 32'd0);

    line(1'b0, 10);
    rxd = 1'b1;
    check("glitch_busy", 32'(busy), 32'd1);
    step(30);
    check("glitch_idle", 32'(busy), 32'd0);
    check("glitch_fe", 32'(fe_cnt), 32'd0);
    check("glitch_rx", 32'(rx_cnt), 32'd1);

    send(8'h3C, 1'b0);
    line(1'b0, 100);
    check("break_busy", 32'(busy), 32'd1);
    check("break_fe", 32'(fe_cnt), 32'd1);
    line(1'b1, 5);
    check("break_idle", 32'(busy), 32'd0);
    step(10);
    exp_q.push_back(8'h11);
    send(8'h11, 1'b1);
    step(20);
    check("b11_left", 32'(exp_q.size()), 32'd0);
    check("b11_rx", 32'(rx_cnt), 32'd2);

    rx_ready = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      if (i <= 4) exp_q.push_back(8'(i));
      send(8'(i), 1'b1);
    end
    step(20);
    check("ovr_cnt", 32'(ov_cnt), 32'd1);
    check("ovr_valid", 32'(rx_valid), 32'd1);
    check("ovr_head", 32'(rx_data), 32'h01);
    rx_ready = 1'b1;
    step(10);
    check("ovr_left", 32'(exp_q.size()), 32'd0);
    check("ovr_empty", 32'(rx_valid), 32'd0);

    rx_ready = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      exp_q.push_back(8'(i));
      send(8'(i), 1'b1);
    end
    exp_q.push_back(8'h05);
    fork
      send(8'h05, 1'b1);
      begin
        step(310);
        rx_ready = 1'b1;
        step(1);
        rx_ready = 1'b0;
      end
    join
    check("sim_ov", 32'(ov_cnt), 32'd1);
    check("sim_head", 32'(rx_data), 32'h02);
    rx_ready = 1'b1;
    step(10);
    check("sim_left", 32'(exp_q.size()), 32'd0);
    check("sim_ov_end", 32'(ov_cnt), 32'd1);

    line(1'b0, BIT);
    line(1'b1, 3 * BIT + 16);
    check("ff_busy", 32'(busy), 32'd1);
    reset_n = 1'b0;
    step(4);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_valid", 32'(rx_valid), 32'd0);
    reset_n = 1'b1;
    step(16 + 5 * BIT);
    exp_q.push_back(8'h5A);
    send(8'h5A, 1'b1);
    step(20);
    check("b5a_left", 32'(exp_q.size()), 32'd0);
    check("end_fe", 32'(fe_cnt), 32'd1);
    check("end_ov", 32'(ov_cnt), 32'd1);
    check("end_rx", 32'(rx_cnt), 32'd12);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
